// File: rtl/kyber_pkg.sv
// Shared types, constants and helpers for the Baby-Kyber encryption engine.
// Ring Z_17[x]/(x^4+1), module rank 2.
package kyber_pkg;

    localparam int Q      = 17;
    localparam int N      = 4;
    localparam int K      = 2;
    localparam int HALF_Q = 9;

    typedef logic signed [31:0] coef_t;
    typedef coef_t    [N-1:0] poly_t;
    typedef poly_t    [K-1:0] polyvec_t;
    typedef polyvec_t [K-1:0] polymat_t;
    typedef poly_t    [1:0][1:0] ct_t;

    // Reduced coefficient in [0,16] and a polynomial of them.
    typedef logic [4:0]     zq_t;
    typedef zq_t  [N-1:0]   zpoly_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_FINAL
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // Signed remainder follows the dividend's sign, so fold negatives back up.
    function automatic coef_t mod_q(input coef_t x);
        coef_t r;
        r = x % Q;
        if (r < 0) r = r + Q;
        return r;
    endfunction

endpackage

// File: rtl/kyber_encrypt_if.sv
// Job handshake and operand/result bus of kyber_encrypt.
// KYBER_ENC_LFSR_EN replaces the noise inputs with a 16-bit seed.
interface kyber_encrypt_if;
    import kyber_pkg::*;

    logic       start;
    polymat_t   pk_a;
    polyvec_t   pk_t;
`ifdef KYBER_ENC_LFSR_EN
    logic [15:0] seed;
`else
    polyvec_t   r_vec;
    polyvec_t   e1_vec;
    poly_t      e2_poly;
`endif
    logic [3:0] msg;
    logic       busy;
    logic       done;
    ct_t        ciphertext;

`ifdef KYBER_ENC_LFSR_EN
    modport master (output start, pk_a, pk_t, seed, msg, input busy, done, ciphertext);
    modport slave  (input start, pk_a, pk_t, seed, msg, output busy, done, ciphertext);
`else
    modport master (output start, pk_a, pk_t, r_vec, e1_vec, e2_poly, msg,
                    input busy, done, ciphertext);
    modport slave  (input start, pk_a, pk_t, r_vec, e1_vec, e2_poly, msg,
                    output busy, done, ciphertext);
`endif

endinterface

// File: rtl/kyber_encrypt_mod_q_mac.sv
// Combinational (acc +/- a*b) mod 17 with all operands already in [0,16].
// With b=1 it doubles as a modular adder for the final noise/message terms.
module mod_q_mac
    import kyber_pkg::*;
(
    input  zq_t  acc_i,
    input  zq_t  a_i,
    input  zq_t  b_i,
    input  logic sub_i,
    output zq_t  res_o
);

    logic [8:0] prod;
    zq_t        prod_red;
    logic [5:0] sum;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        prod     = 9'(a_i) * 9'(b_i);
        prod_red = 5'(prod % 9'd17);
        // Adding Q before subtracting keeps the difference non-negative.
        sum      = sub_i ? 6'(acc_i) + 6'(Q) - 6'(prod_red)
                         : 6'(acc_i) + 6'(prod_red);
        res_o    = (sum >= 6'(Q)) ? 5'(sum - 6'(Q)) : 5'(sum);
    end

endmodule

// File: rtl/kyber_encrypt.sv
// Baby-Kyber encryption: u = A^T*r + e1, v = t^T*r + e2 + encode(msg), one MAC per cycle.
// Optional macro KYBER_ENC_LFSR_EN draws r/e1/e2 from an internal LFSR instead of ports.
module kyber_encrypt
    import kyber_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    kyber_encrypt_if.slave  enc_if
);

    state_t     state_q;
    polymat_t   a_q;
    polyvec_t   t_q, r_q, e1_q;
    poly_t      e2_q;
    logic [3:0] msg_q;
    logic [6:0] cnt_q;
    zq_t        op_a_q, op_b_q;
    logic       op_sub_q, op_vld_q;
    logic [1:0] op_poly_q, op_idx_q;
    zpoly_t [2:0] acc_q;
    ct_t        ct_q;
    logic       busy_q, done_q;

    // MAC step decode: [6:5] target poly (u_0, u_1, v), [4] i, [3:2] a-index, [1:0] b-index.
    logic [1:0] f_poly, f_p, f_q;
    logic       f_i;
    logic [2:0] f_sum;
    zq_t        f_a, f_b;

    always_comb begin
        f_poly = cnt_q[6:5];
        f_i    = cnt_q[4];
        f_p    = cnt_q[3:2];
        f_q    = cnt_q[1:0];
        f_sum  = {1'b0, f_p} + {1'b0, f_q};
        f_a    = (f_poly == 2'd2) ? zq_t'(t_q[f_i][f_p]) : zq_t'(a_q[f_i][f_poly[0]][f_p]);
        f_b    = zq_t'(r_q[f_i][f_q]);
    end

    // Operands are registered one cycle ahead of the accumulate to keep the MAC path short.
    zq_t acc_d;
    mod_q_mac u_mac (
        .acc_i (acc_q[op_poly_q][op_idx_q]),
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sub_i (op_sub_q),
        .res_o (acc_d)
    );

    zpoly_t [1:0] u_fin;
    zpoly_t       v_mid, v_fin;
    for (genvar c = 0; c < N; c++) begin : g_fin
        for (genvar j = 0; j < K; j++) begin : g_u
            mod_q_mac u_add (.acc_i(acc_q[j][c]), .a_i(zq_t'(e1_q[j][c])), .b_i(5'd1),
                             .sub_i(1'b0), .res_o(u_fin[j][c]));
        end
        mod_q_mac u_v_noise (.acc_i(acc_q[2][c]), .a_i(zq_t'(e2_q[c])), .b_i(5'd1),
                             .sub_i(1'b0), .res_o(v_mid[c]));
        // Coefficient c carries msg bit 3-c, the order the decrypt block emits.
        mod_q_mac u_v_msg   (.acc_i(v_mid[c]), .a_i(zq_t'(HALF_Q)), .b_i({4'd0, msg_q[N-1-c]}),
                             .sub_i(1'b0), .res_o(v_fin[c]));
    end

`ifdef KYBER_ENC_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [4:0]  load_cnt_q;
    coef_t       noise_c;

    always_comb begin
        lfsr_d  = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        noise_c = '0;
        case (lfsr_d[1:0])
            2'b01:   noise_c = 1;
            2'b10:   noise_c = Q - 1;
            default: noise_c = '0;
        endcase
    end
`endif

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand and accumulator arrays are reset too; a mid-job abort must leave them zero.
            state_q   <= S_IDLE;
            a_q       <= '0;
            t_q       <= '0;
            r_q       <= '0;
            e1_q      <= '0;
            e2_q      <= '0;
            msg_q     <= '0;
            cnt_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_sub_q  <= 1'b0;
            op_vld_q  <= 1'b0;
            op_poly_q <= '0;
            op_idx_q  <= '0;
            acc_q     <= '0;
            ct_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef KYBER_ENC_LFSR_EN
            lfsr_q     <= '0;
            load_cnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (op_vld_q) acc_q[op_poly_q][op_idx_q] <= acc_d;
            case (state_q)
                S_IDLE: begin
                    if (enc_if.start) begin
                        a_q     <= enc_if.pk_a;
                        t_q     <= enc_if.pk_t;
                        msg_q   <= enc_if.msg;
`ifdef KYBER_ENC_LFSR_EN
                        lfsr_q     <= (enc_if.seed == 16'd0) ? LFSR_SEED_DEFAULT : enc_if.seed;
                        load_cnt_q <= '0;
`else
                        r_q     <= enc_if.r_vec;
                        e1_q    <= enc_if.e1_vec;
                        e2_q    <= enc_if.e2_poly;
`endif
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    for (int i = 0; i < K; i++) begin
                        for (int c = 0; c < N; c++) begin
                            t_q[i][c] <= mod_q(t_q[i][c]);
                            for (int j = 0; j < K; j++) a_q[i][j][c] <= mod_q(a_q[i][j][c]);
                        end
                    end
`ifdef KYBER_ENC_LFSR_EN
                    lfsr_q     <= lfsr_d;
                    load_cnt_q <= load_cnt_q + 5'd1;
                    if (load_cnt_q < 5'd8)       r_q[load_cnt_q[2]][load_cnt_q[1:0]]  <= noise_c;
                    else if (load_cnt_q < 5'd16) e1_q[load_cnt_q[2]][load_cnt_q[1:0]] <= noise_c;
                    else                         e2_q[load_cnt_q[1:0]]                <= noise_c;
                    if (load_cnt_q == 5'd19) begin
                        cnt_q    <= '0;
                        op_vld_q <= 1'b0;
                        state_q  <= S_MAC;
                    end
`else
                    for (int i = 0; i < K; i++) begin
                        for (int c = 0; c < N; c++) begin
                            r_q[i][c]  <= mod_q(r_q[i][c]);
                            e1_q[i][c] <= mod_q(e1_q[i][c]);
                        end
                    end
                    for (int c = 0; c < N; c++) e2_q[c] <= mod_q(e2_q[c]);
                    cnt_q    <= '0;
                    op_vld_q <= 1'b0;
                    state_q  <= S_MAC;
`endif
                end
                S_MAC: begin
                    if (cnt_q < 7'd96) begin
                        op_a_q    <= f_a;
                        op_b_q    <= f_b;
                        op_sub_q  <= f_sum[2];
                        op_idx_q  <= f_sum[1:0];
                        op_poly_q <= f_poly;
                        op_vld_q  <= 1'b1;
                        cnt_q     <= cnt_q + 7'd1;
                    end else begin
                        op_vld_q <= 1'b0;
                        state_q  <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    for (int c = 0; c < N; c++) begin
                        for (int j = 0; j < K; j++) ct_q[0][j][c] <= {27'd0, u_fin[j][c]};
                        ct_q[1][0][c] <= {27'd0, v_fin[c]};
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign enc_if.busy       = busy_q;
    assign enc_if.done       = done_q;
    assign enc_if.ciphertext = ct_q;

endmodule

// File: doc/kyber_encrypt.md
Name: kyber_encrypt

Overview:
- Baby-Kyber encryption engine; produces the ciphertext that the decrypt block consumes.
- Ring: Z_17[x]/(x^4+1), k=2.
- Computes u = A^T·r + e1 and v = t^T·r + e2 + encode(m).
- A single serial modular MAC is driven by an FSM with a start/busy/done handshake; a fixed-latency multicycle job.

Parameters:
- Q, 17, modulus
- N, 4, polynomial coefficients
- K, 2, module rank
- HALF_Q, 9, encoded value of a message 1 bit (round(Q/2))

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin job; sampled in IDLE only
- pk_a  in  signed[31:0] [1:0][1:0][3:0]  public matrix A[i][j][coef]
- pk_t  in  signed[31:0] [1:0][3:0]  public vector t
- r_vec  in  signed[31:0] [1:0][3:0]  ephemeral secret r (absent with KYBER_ENC_LFSR_EN)
- e1_vec  in  signed[31:0] [1:0][3:0]  error e1 (absent with KYBER_ENC_LFSR_EN)
- e2_poly  in  signed[31:0] [3:0]  error e2 (absent with KYBER_ENC_LFSR_EN)
- msg  in  4  message nibble
- busy  out  1  job in progress
- done  out  1  one-cycle pulse; ciphertext valid
- ciphertext  out  signed[31:0] [1:0][1:0][3:0]
  - [0][j] = u_j
  - [1][0] = v
  - [1][1] = 0

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; busy=0, done=0.
  - ciphertext all 0; accumulators and latched inputs 0.
- States: IDLE -> LOAD -> MAC -> FINAL -> IDLE.
- IDLE:
  - start=1 latches all inputs; next state LOAD.
  - Inputs are not re-sampled afterwards, so they may change freely during the job.
- LOAD (1 cycle):
  - Reduce every latched coefficient to [0,16].
  - Coefficients are signed 32-bit; negatives map via the true modulus, e.g. -1 -> 16 and -18 -> 16.
- MAC (96 cycles): one coefficient product per cycle.
  - Order: u_0 (i=0,1), u_1 (i=0,1), then v (i=0,1).
  - Within each polynomial product, a-index outer and b-index inner, each 0..3.
  - Product a[p]·b[q] goes to acc[(p+q) mod 4]; it is subtracted when p+q ≥ 4 (negacyclic).
  - Accumulator stays in [0,16] after every cycle.
  - u_j uses A[i][j] (transpose) times r[i]; v uses t[i]·r[i].
- FINAL (1 cycle):
  - u_j += e1[j].
  - v += e2 + HALF_Q·bit, where coefficient c uses bit msg[3-c] (msg MSB -> coefficient 0), matching the decrypt output bit order.
  - Reduce to [0,16] and register into ciphertext.
  - done=1 in the following cycle (IDLE).
- Timing:
  - busy=1 from the cycle after start through FINAL.
  - Latency: start sampled at edge 0 -> done high after edge 99 (LOAD 1 + MAC 96 + FINAL 1 + register).
- Hold and restart:
  - ciphertext holds until the next FINAL; it is not cleared by start.
  - done is high exactly 1 cycle per job.
- start while busy: ignored, no queuing.
- start coinciding with done (back-to-back): accepted; done still pulses for the finished job.
- Reset mid-job: abort immediately; outputs return to reset values; no done.

Optional Feature:
- Macro: KYBER_ENC_LFSR_EN.
- Defined:
  - Ports r_vec, e1_vec and e2_poly are removed; a seed input (16 bits) is added, latched on start.
  - Internal 16-bit Fibonacci LFSR with taps x^16+x^14+x^13+x^11+1; a seed of 0 is replaced by 16'hACE1.
  - LOAD lasts 20 cycles. Each cycle the LFSR steps once, and its 2 LSBs give one coefficient: 00->0, 01->1, 10->-1 (16), 11->0.
  - Fill order: r[0][0..3], r[1][0..3], e1[0][0..3], e1[1][0..3], e2[0..3].
  - Latency becomes 118 cycles.
- Undefined: noise comes from the ports; latency is 99.

Decomposition:
- Package kyber_pkg:
  - Q, N, K, HALF_Q.
  - typedefs poly_t (signed[31:0] [3:0]), polyvec_t ([1:0] poly_t), polymat_t, ct_t ([1:0][1:0] poly_t).
  - FSM state enum; LFSR taps and default seed.
- Sub-module mod_q_mac: combinational (acc ± a·b) mod Q with operands in [0,16]. It is reused in FINAL for the additions.

Test Plan:
- All A, t, r, e zero; msg=4'b1010 -> u=0, v=(9,0,9,0), done at cycle 99.
- r[0]=(1,0,0,0), t[0]=(1,2,3,4), others 0, msg=0 -> v=(1,2,3,4).
- Negacyclic wrap: t[0]=(0,0,0,1), r[0]=(0,1,0,0) -> v=(16,0,0,0).
- Negative inputs: e1[0]=(-1,-18,17,34), e2=(-1,0,0,0), rest 0, msg=4'b1000 -> u_0=(16,16,0,0), v=(8,0,0,0).
- Protocol:
  - start pulsed again at cycle 50 -> ignored, single done.
  - rst_n low at cycle 40 -> busy=0, ciphertext=0, no done; a fresh start then completes normally.
- Round-trip: random A, s, small r/e in {-1,0,1}, t=A·s+e, random msg -> the decrypt block recovers msg on ≥1000 seeds.
